// File: rtl/rgb_matrix_pixel_gen.sv
// Split-matrix pixel generator: scrollable virtual frame buffers (top/bottom), bit-plane RGB out.
// Latency 2 cycles, one request per cycle, no backpressure; writes never stall reads.
module rgb_matrix_pixel_gen #(
    parameter int COLS      = 32,
    parameter int ROWS_HALF = 8,
    parameter int VIRT_COLS = 1024,
    parameter int BPC       = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [$clog2(COLS)-1:0]                 col_count,
    input  logic [$clog2(ROWS_HALF)-1:0]            row_count,
    input  logic [$clog2(VIRT_COLS)-1:0]            offset,
    input  logic [((BPC > 1) ? $clog2(BPC) : 1)-1:0] plane,
    input  logic                                    blank,
    input  logic                                    pixel_req,
    output logic                                    pixel_valid,
    output logic [2:0]                              LED_Top,
    output logic [2:0]                              LED_Bottom,
    input  logic                                    wr_en,
    input  logic                                    wr_half,
    input  logic [$clog2(ROWS_HALF*VIRT_COLS)-1:0]  wr_addr,
    input  logic [3*BPC-1:0]                        wr_data
);

    localparam int VW    = $clog2(VIRT_COLS);
    localparam int AW    = $clog2(ROWS_HALF*VIRT_COLS);
    localparam int PW    = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DW    = 3*BPC;
    localparam int DEPTH = ROWS_HALF*VIRT_COLS;

    logic [DW-1:0] mem_top [DEPTH];
    logic [DW-1:0] mem_bot [DEPTH];

    logic [VW-1:0] vcol;
    logic [AW-1:0] rd_addr;

    // Stage-1 RAM output registers; not reset, like the RAM itself.
    logic [DW-1:0] rd_top_q;
    logic [DW-1:0] rd_bot_q;

    logic          v1_q,       v1_d;
    logic          blank1_q,   blank1_d;
    logic [PW-1:0] plane1_q,   plane1_d;
    logic          valid_q,    valid_d;
    logic [2:0]    led_top_q,  led_top_d;
    logic [2:0]    led_bot_q,  led_bot_d;

    logic [BPC-1:0] r_top, g_top, b_top;
    logic [BPC-1:0] r_bot, g_bot, b_bot;
    logic           plane_ok;

    // Scroll wraps modulo VIRT_COLS by truncation to the vcol width.
    always_comb begin
        vcol    = offset + VW'(col_count);
        rd_addr = {row_count, vcol};
    end

    // Non-blocking read and write in one block gives read-first on collisions.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_half) begin
            mem_top[wr_addr] <= wr_data;
        end
        if (wr_en && wr_half) begin
            mem_bot[wr_addr] <= wr_data;
        end
        if (pixel_req) begin
            rd_top_q <= mem_top[rd_addr];
            rd_bot_q <= mem_bot[rd_addr];
        end
    end

    always_comb begin
        v1_d     = pixel_req;
        blank1_d = pixel_req & blank;
        plane1_d = plane;
    end

    always_comb begin
        r_top = rd_top_q[3*BPC-1 -: BPC];
        g_top = rd_top_q[2*BPC-1 -: BPC];
        b_top = rd_top_q[BPC-1:0];
        r_bot = rd_bot_q[3*BPC-1 -: BPC];
        g_bot = rd_bot_q[2*BPC-1 -: BPC];
        b_bot = rd_bot_q[BPC-1:0];
        plane_ok = int'(plane1_q) < BPC;

        valid_d   = v1_q;
        led_top_d = led_top_q;
        led_bot_d = led_bot_q;
        if (v1_q) begin
            if (blank1_q || !plane_ok) begin
                led_top_d = 3'b000;
                led_bot_d = 3'b000;
            end else begin
                led_top_d = {r_top[plane1_q], g_top[plane1_q], b_top[plane1_q]};
                led_bot_d = {r_bot[plane1_q], g_bot[plane1_q], b_bot[plane1_q]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q      <= 1'b0;
            blank1_q  <= 1'b0;
            plane1_q  <= '0;
            valid_q   <= 1'b0;
            led_top_q <= 3'b000;
            led_bot_q <= 3'b000;
        end else begin
            v1_q      <= v1_d;
            blank1_q  <= blank1_d;
            plane1_q  <= plane1_d;
            valid_q   <= valid_d;
            led_top_q <= led_top_d;
            led_bot_q <= led_bot_d;
        end
    end

    assign pixel_valid = valid_q;
    assign LED_Top     = led_top_q;
    assign LED_Bottom  = led_bot_q;

endmodule

// File: tb/tb_rgb_matrix_pixel_gen.sv
// Directed bench for rgb_matrix_pixel_gen with hand-computed expected LED patterns.
module tb_rgb_matrix_pixel_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  col_count;
    logic [2:0]  row_count;
    logic [9:0]  offset;
    logic [1:0]  plane;
    logic        blank;
    logic        pixel_req;
    logic        pixel_valid;
    logic [2:0]  LED_Top;
    logic [2:0]  LED_Bottom;
    logic        wr_en;
    logic        wr_half;
    logic [12:0] wr_addr;
    logic [11:0] wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_matrix_pixel_gen #(
        .COLS(32), .ROWS_HALF(8), .VIRT_COLS(1024), .BPC(4)
    ) dut (
        .clk(clk), .reset(reset),
        .col_count(col_count), .row_count(row_count), .offset(offset),
        .plane(plane), .blank(blank), .pixel_req(pixel_req),
        .pixel_valid(pixel_valid), .LED_Top(LED_Top), .LED_Bottom(LED_Bottom),
        .wr_en(wr_en), .wr_half(wr_half), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic half, input logic [2:0] row, input logic [9:0] vc,
                      input logic [11:0] dat);
        wr_en   = 1'b1;
        wr_half = half;
        wr_addr = {row, vc};
        wr_data = dat;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic req(input logic [2:0] row, input logic [4:0] col, input logic [9:0] off,
                       input logic [1:0] pl, input logic blk);
        pixel_req = 1'b1;
        row_count = row;
        col_count = col;
        offset    = off;
        plane     = pl;
        blank     = blk;
    endtask

    logic [2:0] exp_top [4] = '{3'b010, 3'b100, 3'b011, 3'b101};
    logic [2:0] exp_bot [4] = '{3'b110, 3'b110, 3'b010, 3'b010};

    initial begin
        reset = 1'b1; pixel_req = 1'b0; blank = 1'b0; plane = '0;
        col_count = '0; row_count = '0; offset = '0;
        wr_en = 1'b0; wr_half = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset held with requests pending
        req(3'd0, 5'd0, 10'd0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", pixel_valid, 0);
            chk("rst_top", LED_Top, 0);
            chk("rst_bot", LED_Bottom, 0);
        end
        reset = 1'b0;
        tick();
        chk("rel_valid0", pixel_valid, 0);
        chk("rel_top0", LED_Top, 0);
        pixel_req = 1'b0;
        tick();
        chk("rel_valid1", pixel_valid, 1);
        tick();
        chk("rel_valid2", pixel_valid, 0);

        // Buffer setup
        for (int v = 0; v < 8; v++) begin
            wr(1'b0, 3'd0, 10'(v), 12'h000);
            wr(1'b1, 3'd0, 10'(v), 12'h000);
        end
        wr(1'b0, 3'd0, 10'd5, 12'hA5C);
        wr(1'b1, 3'd0, 10'd5, 12'h3F0);
        wr(1'b0, 3'd0, 10'd2, 12'hFFF);
        wr(1'b0, 3'd3, 10'd9, 12'hFFF);
        wr(1'b0, 3'd2, 10'd9, 12'h000);
        wr(1'b0, 3'd1, 10'd20, 12'h000);

        // Plane select, back-to-back
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                chk("plane_valid", pixel_valid, 1);
                chk($sformatf("plane%0d_top", i-2), LED_Top, exp_top[i-2]);
                chk($sformatf("plane%0d_bot", i-2), LED_Bottom, exp_bot[i-2]);
            end
            if (i < 4) req(3'd0, 5'd5, 10'd0, 2'(i), 1'b0);
            else pixel_req = 1'b0;
            tick();
        end
        chk("plane_idle_valid", pixel_valid, 0);
        chk("plane_hold_top", LED_Top, 3'b101);

        // Scroll wrap
        req(3'd0, 5'd6, 10'd1020, 2'd0, 1'b0);
        tick();
        req(3'd0, 5'd6, 10'd1019, 2'd0, 1'b0);
        tick();
        pixel_req = 1'b0;
        chk("wrap_top", LED_Top, 3'b111);
        chk("wrap_bot", LED_Bottom, 3'b000);
        tick();
        chk("wrap_prev_top", LED_Top, 3'b000);
        chk("wrap_prev_valid", pixel_valid, 1);

        // Row addressing
        req(3'd3, 5'd9, 10'd0, 2'd2, 1'b0);
        tick();
        req(3'd2, 5'd9, 10'd0, 2'd2, 1'b0);
        tick();
        pixel_req = 1'b0;
        chk("row3_top", LED_Top, 3'b111);
        tick();
        chk("row2_top", LED_Top, 3'b000);

        // Read-first collision
        req(3'd1, 5'd20, 10'd0, 2'd0, 1'b0);
        wr_en = 1'b1; wr_half = 1'b0; wr_addr = {3'd1, 10'd20}; wr_data = 12'hFFF;
        tick();
        wr_en = 1'b0;
        tick();
        pixel_req = 1'b0;
        chk("coll_old", LED_Top, 3'b000);
        chk("coll_old_valid", pixel_valid, 1);
        tick();
        chk("coll_new", LED_Top, 3'b111);

        // Blank then idle hold
        req(3'd0, 5'd2, 10'd0, 2'd0, 1'b1);
        tick();
        pixel_req = 1'b0; blank = 1'b0;
        tick();
        chk("blank_valid", pixel_valid, 1);
        chk("blank_top", LED_Top, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", pixel_valid, 0);
            chk("idle_top", LED_Top, 3'b000);
        end

        // Reset mid-stream
        req(3'd0, 5'd2, 10'd0, 2'd0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pixel_req = 1'b0;
        chk("mid_rst_t2", pixel_valid, 0);
        tick();
        chk("mid_rst_t3", pixel_valid, 0);
        tick();
        chk("mid_rst_t4", pixel_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
